fetch_pc: RTL and testbench

- Fetch-stage PC unit; consumes the next-PC and redirect results of the jump/branch ALU and produces the instruction stream for decode.
- Holds the architectural PC and issues one-outstanding requests to a variable-latency instruction memory.
- Buffers one fetched instruction behind a valid/ready handshake to decode, and tracks halt.
- Flushes wrong-path work on redirect.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/cla16b.sv | 45 ++++
 rtl/fetch_pc.sv | 122 ++++++++++++
 tb/tb_fetch_pc.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-stage PC unit.
// State encoding, HALT opcode and PC increment.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [4:0]  HALT_OP = 5'b00000;
  localparam logic [15:0] PC_INC  = 16'h0002;

endpackage

// File: rtl/cla16b.sv
// 16-bit carry-lookahead adder, four 4-bit groups.
// Ports: a, b, c_in in; sum, c_out out.
module cla16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;
  logic [4:0]  gc;
  logic        gg;
  logic        gp;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    c  = '0;
    gc = '0;
    gg = 1'b0;
    gp = 1'b0;
    gc[0] = c_in;
    for (int k = 0; k < 4; k++) begin
      // group generate/propagate give the carry into the next group
      gg = g[4*k+3]
         | (p[4*k+3] & g[4*k+2])
         | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | ((&p[4*k+1 +: 3]) & g[4*k]);
      gp = &p[4*k +: 4];
      gc[k+1] = gg | (gp & gc[k]);
      c[4*k] = gc[k];
      for (int i = 0; i < 3; i++) begin
        c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
      end
      c[4*k+4] = gc[k+1];
    end
  end

  assign sum   = p ^ c[15:0];
  assign c_out = gc[4];

endmodule

// File: rtl/fetch_pc.sv
// Fetch-stage PC unit: one-outstanding imem requests, one-entry output buffer.
// Ports: clk, rst, redirect_*, imem_* request/response, if_* to decode, halted, err.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          TIMEOUT  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_done,
  input  logic [15:0] imem_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  output logic        halted,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] TM1  = CW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nx;
  logic [15:0]   pc;
  logic [15:0]   pc_inc;
  logic          squash;
  logic [CW-1:0] cnt;
  logic          take;
  logic          is_halt;
  logic          unused_cout;

  cla16b u_add (
    .a     (pc),
    .b     (PC_INC),
    .c_in  (1'b0),
    .sum   (pc_inc),
    .c_out (unused_cout)
  );

  assign is_halt   = imem_data[15:11] == HALT_OP;
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= REQ;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    take     = 1'b0;
    unique case (state)
      REQ: begin
        if ((!if_valid || if_ready) && !redirect_valid) begin
          imem_req = !rst;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (imem_done) begin
          // squashed or redirected data is dropped
          take     = !squash && !redirect_valid;
          state_nx = (take && is_halt) ? HALTED : REQ;
        end
      end
      HALTED: begin
        if (redirect_valid) state_nx = REQ;
      end
      default: state_nx = REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus2 <= '0;
      halted      <= 1'b0;
      err         <= 1'b0;
      squash      <= 1'b0;
      cnt         <= '0;
    end else begin
      halted <= state_nx == HALTED;
      if (redirect_valid) begin
        pc       <= {redirect_pc[15:1], 1'b0};
        if_valid <= 1'b0;
        if (redirect_pc[0]) err <= 1'b1;
      end else if (take) begin
        pc          <= pc_inc;
        if_valid    <= 1'b1;
        if_instr    <= imem_data;
        if_pc       <= pc;
        if_pc_plus2 <= pc_inc;
      end else if (if_valid && if_ready) begin
        if_valid <= 1'b0;
      end
      if (state == WAIT) begin
        if (imem_done)           squash <= 1'b0;
        else if (redirect_valid) squash <= 1'b1;
      end else begin
        squash <= 1'b0;
      end
      if (state == WAIT && !imem_done) begin
        if (cnt != TMAX) cnt <= cnt + CW'(1);
        if (cnt == TM1)  err <= 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc.sv
// Directed bench for fetch_pc with a transaction-level reference model.
// Memory responder, per-cycle compare, literal scenario checks.
module tb_fetch_pc;

  localparam int TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_done = 1'b0;
  logic [15:0] imem_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;
  logic        halted;
  logic        err;

  fetch_pc #(.RESET_PC(16'h0000), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_done      (imem_done),
    .imem_data      (imem_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus2    (if_pc_plus2),
    .halted         (halted),
    .err            (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // memory responder
  int          lat  = 1;
  bit          hold = 0;
  bit          pend = 0;
  int          mcnt = 0;
  logic [15:0] ma   = '0;
  logic [15:0] halt_addr = 16'h0001;

  // reference model: fetch outstanding, buffer contents, flags
  logic [15:0] m_pc;
  bit          m_out, m_sq, m_bv, m_halt, m_err;
  logic [15:0] m_bi, m_bp;
  int          m_wait;

  logic [15:0] req_log[$];
  logic [15:0] acc_log[$];

  function automatic void chk16(string nm, logic [15:0] a, logic [15:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endfunction

  function automatic void chk1(string nm, logic a, logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, a, e);
    end
  endfunction

  function automatic void chk_log(string nm, int which, int idx, logic [15:0] e);
    int sz;
    sz = (which == 0) ? req_log.size() : acc_log.size();
    if (idx >= sz) begin
      total++;
      bad++;
      $display("FAIL %s: entry %0d missing (have %0d) want %h", nm, idx, sz, e);
    end else begin
      chk16(nm, (which == 0) ? req_log[idx] : acc_log[idx], e);
    end
  endfunction

  function automatic logic [15:0] word(logic [15:0] a);
    return (a == halt_addr) ? 16'h0000 : {5'b10011, a[10:0]};
  endfunction

  function automatic void mem_drive();
    if (pend && mcnt > 0) mcnt--;
    imem_done = pend && mcnt == 0 && !hold;
    imem_data = imem_done ? word(ma) : 16'h0000;
  endfunction

  function automatic void model_reset();
    m_pc = 16'h0000; m_out = 0; m_sq = 0; m_bv = 0;
    m_halt = 0; m_err = 0; m_bi = '0; m_bp = '0; m_wait = 0;
  endfunction

  task automatic cycle();
    bit          er, d, r;
    logic [15:0] dat;
    @(negedge clk);
    r   = redirect_valid;
    d   = imem_done;
    dat = imem_data;
    er  = !m_out && !m_halt && (!m_bv || if_ready) && !r;
    chk1("imem_req", imem_req, er);
    if (er) chk16("imem_addr", imem_addr, m_pc);
    chk1("if_valid", if_valid, m_bv);
    if (m_bv) begin
      chk16("if_instr", if_instr, m_bi);
      chk16("if_pc", if_pc, m_bp);
      chk16("if_pc_plus2", if_pc_plus2, m_bp + 16'd2);
    end
    chk1("halted", halted, m_halt);
    chk1("err", err, m_err);
    if (imem_req) req_log.push_back(imem_addr);
    if (if_valid && if_ready) acc_log.push_back(if_pc);
    if (d) pend = 0;
    if (er) begin pend = 1; mcnt = lat; ma = m_pc; end
    if (m_bv && if_ready) m_bv = 0;
    if (m_out) begin
      if (d) begin
        m_out = 0; m_wait = 0;
        if (!m_sq && !r) begin
          m_bv = 1; m_bi = dat; m_bp = m_pc;
          m_pc = m_pc + 16'd2;
          m_halt = dat[15:11] == 5'd0;
        end
        m_sq = 0;
      end else begin
        m_wait++;
        if (m_wait >= TIMEOUT) m_err = 1;
        if (r) m_sq = 1;
      end
    end else if (er) begin
      m_out = 1; m_wait = 0;
    end
    if (r) begin
      m_pc = {redirect_pc[15:1], 1'b0};
      m_bv = 0; m_halt = 0;
      if (redirect_pc[0]) m_err = 1;
    end
    @(posedge clk);
    #1;
    mem_drive();
  endtask

  task automatic cycles(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset(bit clear_mem);
    @(posedge clk);
    #1;
    rst = 1; redirect_valid = 0; if_ready = 1;
    #1;
    chk1("rst_imem_req", imem_req, 1'b0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk16("rst_if_instr", if_instr, 16'h0000);
    chk16("rst_if_pc", if_pc, 16'h0000);
    chk16("rst_if_pc_plus2", if_pc_plus2, 16'h0000);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_err", err, 1'b0);
    model_reset();
    if (clear_mem) begin
      pend = 0; hold = 0; imem_done = 0; imem_data = '0;
    end
    @(posedge clk);
    #1;
    rst = 0;
    mem_drive();
    req_log.delete();
    acc_log.delete();
  endtask

  task automatic redirect(logic [15:0] t);
    redirect_valid = 1; redirect_pc = t;
    cycle();
    redirect_valid = 0;
  endtask

  initial begin
    model_reset();
    // 1-cycle memory, decode always ready
    lat = 1;
    do_reset(1);
    cycle();
    chk1("s1_valid_c1", if_valid, 1'b0);
    cycle();
    chk1("s1_valid_c2", if_valid, 1'b1);
    chk16("s1_pc_c2", if_pc, 16'h0000);
    chk16("s1_pc2_c2", if_pc_plus2, 16'h0002);
    cycles(4);
    chk_log("s1_addr0", 0, 0, 16'h0000);
    chk_log("s1_addr1", 0, 1, 16'h0002);
    chk_log("s1_addr2", 0, 2, 16'h0004);

    // decode stalls after the first instruction is taken
    do_reset(1);
    cycles(3);
    if_ready = 0;
    cycles(5);
    chk16("s2_req_count", 16'(req_log.size()), 16'd2);
    chk_log("s2_addr1", 0, 1, 16'h0002);
    chk1("s2_held_valid", if_valid, 1'b1);
    chk16("s2_held_pc", if_pc, 16'h0002);
    if_ready = 1;
    cycles(3);
    chk16("s2_acc_count", 16'(acc_log.size()), 16'd3);
    chk_log("s2_acc0", 1, 0, 16'h0000);
    chk_log("s2_acc1", 1, 1, 16'h0002);
    chk_log("s2_acc2", 1, 2, 16'h0004);

    // 4-cycle memory, redirect during the second WAIT cycle
    lat = 4;
    do_reset(1);
    cycles(2);
    redirect(16'h0040);
    cycles(3);
    chk1("s3_dropped", if_valid, 1'b0);
    chk_log("s3_target", 0, 1, 16'h0040);
    cycles(4);
    chk1("s3_valid", if_valid, 1'b1);
    chk16("s3_pc", if_pc, 16'h0040);
    lat = 1;

    // HALT word at 0x0010, then resume at 0x0020
    halt_addr = 16'h0010;
    do_reset(1);
    redirect(16'h0010);
    cycles(2);
    chk1("s4_valid", if_valid, 1'b1);
    chk16("s4_pc", if_pc, 16'h0010);
    chk16("s4_instr", if_instr, 16'h0000);
    chk1("s4_halted", halted, 1'b1);
    cycles(4);
    chk16("s4_no_req", 16'(req_log.size()), 16'd1);
    chk1("s4_still_halted", halted, 1'b1);
    redirect(16'h0020);
    chk1("s4_resumed", halted, 1'b0);
    cycle();
    chk_log("s4_resume_addr", 0, 1, 16'h0020);
    halt_addr = 16'h0001;

    // misaligned redirect
    do_reset(1);
    redirect(16'h0031);
    chk1("s5_err", err, 1'b1);
    cycle();
    chk_log("s5_addr", 0, 0, 16'h0030);
    cycles(4);
    chk1("s5_err_sticky", err, 1'b1);

    // wrap past 0xFFFE, then withheld response
    do_reset(1);
    redirect(16'hFFFE);
    cycles(2);
    chk16("s6_pc", if_pc, 16'hFFFE);
    chk16("s6_pc_plus2", if_pc_plus2, 16'h0000);
    hold = 1;
    cycle();
    chk_log("s6_wrap_addr", 0, 1, 16'h0000);
    chk1("s6_no_err", err, 1'b0);
    cycles(TIMEOUT - 1);
    chk1("s6_err_early", err, 1'b0);
    cycle();
    chk1("s6_timeout", err, 1'b1);
    cycles(3);
    chk1("s6_err_sticky", err, 1'b1);

    // reset mid-WAIT; the stale response lands in REQ
    hold = 0;
    do_reset(0);
    cycles(4);
    chk1("s7_err_clear", err, 1'b0);
    chk_log("s7_addr0", 0, 0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
